// File: rtl/seq_divider.sv
// seq_divider: sequential non-restoring divider, one quotient bit per clock.
//
// Loading protocol: a start pulse in IDLE, then the dividend and the divisor
// on data_in on the two following cycles. The quotient and remainder registers
// update once per division (at the FIX edge, or at the divisor-load edge for a
// zero divisor) and hold until the next result. done pulses for one cycle.
//
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (truncating division: remainder takes the dividend's sign). Without it the
// operands are unsigned and no sign logic is built.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset, clears every register
//   start        request a division (sampled in IDLE only)
//   data_in      operand bus: dividend, then divisor
//   quotient     registered quotient (all ones on divide-by-zero)
//   remainder    registered remainder (raw dividend on divide-by-zero)
//   busy         high in every state except IDLE
//   done         one-cycle pulse when quotient/remainder are valid
//   div_by_zero  set with done for a zero divisor, cleared at the next start
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LDQ  = 3'd1;
   localparam logic [2:0] S_LDM  = 3'd2;
   localparam logic [2:0] S_CALC = 3'd3;
   localparam logic [2:0] S_FIX  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   logic [2:0]       state;
   logic [2:0]       state_next;

   // Partial remainder A (one extra bit for the sign), dividend/quotient Q,
   // divisor M and iteration counter.
   logic [WIDTH:0]   a_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   a_shift;
   logic [WIDTH:0]   a_step;
   logic [WIDTH:0]   a_fix;
   logic [WIDTH-1:0] operand_mag;
   logic [WIDTH-1:0] quot_out;
   logic [WIDTH-1:0] rem_out;
   logic [WIDTH-1:0] raw_dividend;
   logic             divisor_zero;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic             q_sign;
   logic             m_sign;
`endif

   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign divisor_zero = (data_in == '0);

   // One non-restoring step: shift {A,Q} left, then subtract M when the old A
   // was non-negative, add it back otherwise. Everything wraps modulo
   // 2^(WIDTH+1), which is exact because A always stays within [-M, M).
   assign m_ext   = {1'b0, m_reg};
   assign a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
   assign a_step  = a_reg[WIDTH] ? (a_shift + m_ext) : (a_shift - m_ext);

   // Final restore of a negative partial remainder.
   assign a_fix   = a_reg[WIDTH] ? (a_reg + m_ext) : a_reg;

`ifdef SEQ_DIVIDER_SIGNED_EN
   // Operands are stored as magnitudes; the most-negative value maps onto
   // itself, which the unsigned core then treats as 2^(WIDTH-1).
   assign operand_mag  = data_in[WIDTH-1] ? (-data_in) : data_in;
   assign quot_out     = (q_sign ^ m_sign) ? (-q_reg) : q_reg;
   assign rem_out      = q_sign ? (-a_fix[WIDTH-1:0]) : a_fix[WIDTH-1:0];
   // Q still holds the untouched dividend magnitude when the divisor is seen,
   // so re-applying the sign recovers the raw dividend bits.
   assign raw_dividend = q_sign ? (-q_reg) : q_reg;
`else
   assign operand_mag  = data_in;
   assign quot_out     = q_reg;
   assign rem_out      = a_fix[WIDTH-1:0];
   assign raw_dividend = q_reg;
`endif

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_LDQ;
         S_LDQ:   state_next = S_LDM;
         S_LDM:   state_next = divisor_zero ? S_DONE : S_CALC;
         S_CALC:  if (count == CW'(1)) state_next = S_FIX;
         S_FIX:   state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg       <= '0;
         q_reg       <= '0;
         m_reg       <= '0;
         count       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
         q_sign      <= 1'b0;
         m_sign      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_reg       <= '0;
                  div_by_zero <= 1'b0;
               end
            end
            S_LDQ: begin
               q_reg  <= operand_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
               q_sign <= data_in[WIDTH-1];
`endif
            end
            S_LDM: begin
               m_reg  <= operand_mag;
               count  <= CW'(WIDTH);
`ifdef SEQ_DIVIDER_SIGNED_EN
               m_sign <= data_in[WIDTH-1];
`endif
               if (divisor_zero) begin
                  quotient    <= '1;
                  remainder   <= raw_dividend;
                  div_by_zero <= 1'b1;
               end
            end
            S_CALC: begin
               a_reg <= a_step;
               q_reg <= {q_reg[WIDTH-2:0], ~a_step[WIDTH]};
               count <= count - CW'(1);
            end
            S_FIX: begin
               a_reg     <= a_fix;
               quotient  <= quot_out;
               remainder <= rem_out;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed vectors, scoreboard queue filled by the
// driver, popped and compared by an independent monitor on the falling edge.
module tb_seq_divider;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  data_in;
   logic [W-1:0]  quotient;
   logic [W-1:0]  remainder;
   logic          busy;
   logic          done;
   logic          div_by_zero;

   seq_divider #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .data_in(data_in),
      .quotient(quotient),
      .remainder(remainder),
      .busy(busy),
      .done(done),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Hand-computed expectations that differ between the two builds.
`ifdef SEQ_DIVIDER_SIGNED_EN
   localparam logic [15:0] Q_NEG100 = 16'hFFF2, R_NEG100 = 16'hFFFE;  // -100/7
   localparam logic [15:0] Q_FFFF   = 16'h0000, R_FFFF   = 16'hFFFF;  // -1/2
   localparam logic [15:0] Q_8000   = 16'h8000, R_8000   = 16'h0000;  // min/-1
   localparam logic [15:0] Q_C350   = 16'hEBC6, R_C350   = 16'hFFFE;  // -15536/3
`else
   localparam logic [15:0] Q_NEG100 = 16'h2484, R_NEG100 = 16'h0000;  // 65436/7
   localparam logic [15:0] Q_FFFF   = 16'h7FFF, R_FFFF   = 16'h0001;  // 65535/2
   localparam logic [15:0] Q_8000   = 16'h0000, R_8000   = 16'h8000;  // 32768/65535
   localparam logic [15:0] Q_C350   = 16'h411A, R_C350   = 16'h0002;  // 50000/3
`endif

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          t;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [15:0] held_q  = '0;
   logic [15:0] held_r  = '0;
   bit          hold_bad = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Rising-edge counter; read by driver and monitor away from the edge.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: compares every done pulse against the scoreboard and tracks
   // that results never move outside a done cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held_q   = '0;
            held_r   = '0;
            hold_bad = 1'b0;
         end else if (done) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1, expected no pending result");
            end else begin
               e = sb.pop_front();
               check("quotient", quotient, e.q);
               check("remainder", remainder, e.r);
               check("div_by_zero", div_by_zero, e.dz);
               check("done_cycle", cyc, e.t);
               check("result_hold", hold_bad, 1'b0);
            end
            held_q   = quotient;
            held_r   = remainder;
            hold_bad = 1'b0;
         end else if (quotient !== held_q || remainder !== held_r) begin
            hold_bad = 1'b1;
         end
      end
   end

   // Called at posedge+1 with the DUT idle. Returns at E2+1 (or later if a
   // stray start pulse is requested at edge E<pulse_at>).
   task automatic issue(input logic [15:0] dd, input logic [15:0] dv,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edz, input bit push, input int pulse_at);
      int e0;
      start = 1'b1;
      @(posedge clk); #1;
      e0      = cyc;
      start   = 1'b0;
      data_in = dd;
      check("start_clears_dz", div_by_zero, 1'b0);
      check("busy_after_start", busy, 1'b1);
      @(posedge clk); #1;
      data_in = dv;
      @(posedge clk); #1;
      data_in = 16'hA5A5;
      if (push) sb.push_back('{eq, er, edz, e0 + (edz ? 2 : W + 3)});
      if (pulse_at > 3) begin
         repeat (pulse_at - 3) @(posedge clk);
         #1 start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
      end
   endtask

   task automatic run(input logic [15:0] dd, input logic [15:0] dv,
                      input logic [15:0] eq, input logic [15:0] er,
                      input logic edz, input int pulse_at);
      issue(dd, dv, eq, er, edz, 1'b1, pulse_at);
      wait_done();
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      @(posedge clk); #2;
      check("rst_quotient", quotient, 16'h0);
      check("rst_remainder", remainder, 16'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dz", div_by_zero, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run(16'd100,  16'd7,      16'd14,   16'd2,    1'b0, 0);
      run(16'hFF9C, 16'd7,      Q_NEG100, R_NEG100, 1'b0, 0);
      run(16'd20,   16'hFFE2,   16'd0,    16'd20,   1'b0, 0);
      run(16'd5,    16'd0,      16'hFFFF, 16'd5,    1'b1, 0);
      run(16'hFFFF, 16'd2,      Q_FFFF,   R_FFFF,   1'b0, 0);
      run(16'h8000, 16'hFFFF,   Q_8000,   R_8000,   1'b0, 0);
      // stray start pulse sampled at E5, mid-CALC
      run(16'd1000, 16'd1000,   16'd1,    16'd0,    1'b0, 5);
      run(16'hFFF6, 16'd0,      16'hFFFF, 16'hFFF6, 1'b1, 0);

      // Reset at E8 mid-CALC: outputs clear asynchronously, no result appears.
      issue(16'd100, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0, 0);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("midrst_quotient", quotient, 16'h0);
      check("midrst_remainder", remainder, 16'h0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_dz", div_by_zero, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("post_rst_idle", busy, 1'b0);

      // Back-to-back: second start sampled one cycle after done falls.
      issue(16'h1234, 16'h0010, 16'h0123, 16'h0004, 1'b0, 1'b1, 0);
      wait_done();
      @(posedge clk); #1;
      run(16'hC350, 16'd3, Q_C350, R_C350, 1'b0, 0);

      repeat (4) @(posedge clk);
      #1 check("scoreboard_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
